// File: rtl/pipelined_adder_if.sv
// Handshake bundle for pipelined_adder.
//   master : operand source / result sink (drives in_valid, a, b, cin, sub, out_ready)
//   slave  : the adder (drives in_ready, out_valid, sum, cout, ovf)
// The sub signal exists only when ADDER_SUB_EN is defined.
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin,
`ifdef ADDER_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef ADDER_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder. Operands are split into STAGES chunks of
// CW = WIDTH/STAGES bits; stage k adds chunk k and registers the partial
// sum and carry, so the carry ripples one chunk per clock.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : pipelined_adder_if.slave (valid/ready in, valid/ready out,
//         a, b, cin, [sub], sum, cout, ovf)
// Option: ADDER_SUB_EN adds the sub input (A + ~B + 1, cin ignored).
// The whole pipeline moves as one: en = !out_valid || out_ready.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic                clk,
  input  logic                rst,
  pipelined_adder_if.slave    bus
);
  localparam int CW = WIDTH / STAGES;

  // Index k is the input of stage k; index k+1 is its registered output.
  // Operands are shifted down by CW per stage so every stage adds bits
  // [CW-1:0]; the sum is shifted in from the top so chunk 0 lands at
  // the bottom after the last stage.
  logic             vld_pipe [0:STAGES];
  logic [WIDTH-1:0] s_pipe   [0:STAGES];
  logic             c_pipe   [0:STAGES];
  logic [WIDTH-1:0] a_pipe   [0:STAGES-1];
  logic [WIDTH-1:0] b_pipe   [0:STAGES-1];
  logic             ovf_q;
  logic             en;

  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  assign vld_pipe[0] = bus.in_valid;
  assign a_pipe[0]   = bus.a;
  assign s_pipe[0]   = '0;
`ifdef ADDER_SUB_EN
  // Subtract folds into the add: invert B once at entry, force carry-in.
  assign b_pipe[0] = bus.sub ? ~bus.b : bus.b;
  assign c_pipe[0] = bus.sub ? 1'b1   : bus.cin;
`else
  assign b_pipe[0] = bus.b;
  assign c_pipe[0] = bus.cin;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [CW:0] part;
    assign part = {1'b0, a_pipe[k][CW-1:0]} + {1'b0, b_pipe[k][CW-1:0]}
                + {{CW{1'b0}}, c_pipe[k]};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_pipe[k+1] <= 1'b0;
        s_pipe[k+1]   <= '0;
        c_pipe[k+1]   <= 1'b0;
      end else if (en) begin
        vld_pipe[k+1] <= vld_pipe[k];
        s_pipe[k+1]   <= WIDTH'({part[CW-1:0], s_pipe[k]} >> CW);
        c_pipe[k+1]   <= part[CW];
      end
    end

    if (k < STAGES-1) begin : g_ops
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_pipe[k+1] <= '0;
          b_pipe[k+1] <= '0;
        end else if (en) begin
          a_pipe[k+1] <= a_pipe[k] >> CW;
          b_pipe[k+1] <= b_pipe[k] >> CW;
        end
      end
    end else begin : g_ovf
      // Carry into the MSB is recovered from the MSB sum bit:
      // s = a ^ b ^ c_in  =>  c_in = a ^ b ^ s.
      logic msb_cin;
      assign msb_cin = a_pipe[k][CW-1] ^ b_pipe[k][CW-1] ^ part[CW-1];
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     ovf_q <= 1'b0;
        else if (en) ovf_q <= msb_cin ^ part[CW];
      end
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.sum       = s_pipe[STAGES];
  assign bus.cout      = c_pipe[STAGES];
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4).
// A beat-level model (a row of STAGES slots that moves whenever the
// output is free) predicts out_valid/in_ready/sum/cout/ovf every cycle;
// directed tests add literal expectations.
module tb_pipelined_adder;
  localparam int W = 16;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(W)) bus ();
  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {ovf, cout, sum} from plain arithmetic.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic         ci;
    logic [W:0]   t;
    logic         v;
    bb = sub ? ~b : b;
    ci = sub ? 1'b1 : cin;
    t  = {1'b0, a} + {1'b0, bb} + (W+1)'(ci);
    v  = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    return {v, t[W], t[W-1:0]};
  endfunction

  logic sub_now;
`ifdef ADDER_SUB_EN
  assign sub_now = bus.sub;
`else
  assign sub_now = 1'b0;
`endif

  // Beat-level model: slot S-1 is what must be on the output.
  logic           mv [S];
  logic [W+1:0]   md [S];
  initial for (int i = 0; i < S; i++) begin mv[i] = 1'b0; md[i] = '0; end

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < S; i++) mv[i] = 1'b0;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready",  bus.in_ready,  1);
      chk("rst_sum",       bus.sum,       0);
    end else begin
      chk("out_valid", bus.out_valid, mv[S-1]);
      chk("in_ready",  bus.in_ready,  !mv[S-1] || bus.out_ready);
      if (mv[S-1]) begin
        chk("sum",  bus.sum,  md[S-1][W-1:0]);
        chk("cout", bus.cout, md[S-1][W]);
        chk("ovf",  bus.ovf,  md[S-1][W+1]);
      end
      if (!mv[S-1] || bus.out_ready) begin
        for (int i = S-1; i > 0; i--) begin mv[i] = mv[i-1]; md[i] = md[i-1]; end
        mv[0] = bus.in_valid;
        md[0] = ref_add(bus.a, bus.b, bus.cin, sub_now);
      end
    end
  end

  logic [W-1:0] va [16];
  logic [W-1:0] vb [16];
  logic         vc [16];
  logic         vs [16];

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
`ifdef ADDER_SUB_EN
    bus.sub      = sub;
`else
    if (sub) $display("note: sub requested in add-only build");
`endif
  endtask

  // Vector i: chunk-0 LSBs of a/b/cin walk all 8 combinations.
  task automatic load_vecs(input int seed);
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] x, y;
      logic [3:0]   ii;
      ii = 4'(i);
      x = 16'(16'h1357 * (i + seed + 1));
      y = 16'hF0E1 ^ 16'(16'h0919 * i);
      va[i] = {x[W-1:1], ii[2]};
      vb[i] = {y[W-1:1], ii[1]};
      vc[i] = ii[0];
      vs[i] = (seed != 0) && ii[0];
    end
  endtask

  // One beat with an empty pipe and out_ready=1; literal result check.
  task automatic run_one(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub,
                         input logic [W-1:0] es, input logic ec, input logic eo);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive(1'b1, a, b, cin, sub);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (S-1) @(posedge clk);
    #1;
    chk({nm, "_valid"}, bus.out_valid, 1);
    chk({nm, "_sum"},   bus.sum,       es);
    chk({nm, "_cout"},  bus.cout,      ec);
    chk({nm, "_ovf"},   bus.ovf,       eo);
  endtask

  // Send n table beats; bit c of vmask/rmask gives in_valid/out_ready
  // in cycle c (1 beyond bit 15). Beats are held until accepted.
  task automatic run_stream(input int n, input logic [15:0] vmask, input logic [15:0] rmask);
    int sent = 0;
    int c = 0;
    while (sent < n && c < 200) begin
      @(posedge clk); #1;
      drive((c >= 16) ? 1'b1 : vmask[c], va[sent], vb[sent], vc[sent], vs[sent]);
      bus.out_ready = (c >= 16) ? 1'b1 : rmask[c];
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) sent++;
      c++;
    end
    if (c >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL stream_timeout: sent %0d of %0d", sent, n);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (S + 2) @(posedge clk);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #3;
    chk("por_out_valid", bus.out_valid, 0);
    chk("por_sum",       bus.sum,       0);
    chk("por_cout",      bus.cout,      0);
    chk("por_ovf",       bus.ovf,       0);
    chk("por_in_ready",  bus.in_ready,  1);
    @(posedge clk); #1 rst = 1'b0;

    run_one("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("cin",    16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

    load_vecs(0);
    run_stream(8, 16'hFFFF, 16'hFFFF);                  // full rate
    load_vecs(1);
    run_stream(6, 16'hFFFF, 16'hFF8F);                  // stall cycles 4..6
    load_vecs(2);
    run_stream(4, 16'hFF2D, 16'hFFFF);                  // valid 1,0,1,1,0,1

`ifdef ADDER_SUB_EN
    run_one("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    // Async reset with three beats in flight.
    load_vecs(3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(1'b1, va[i], vb[i], vc[i], 1'b0);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_sum",       bus.sum,       0);
    chk("arst_cout",      bus.cout,      0);
    chk("arst_ovf",       bus.ovf,       0);
    chk("arst_in_ready",  bus.in_ready,  1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (S + 1) @(posedge clk);
    #1 chk("arst_no_stale", bus.out_valid, 0);
    run_one("post_rst", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

    @(posedge clk); #1;
    chk("idle_out_valid", bus.out_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined N-bit binary adder: the sequential successor to the single-bit combinational full adder. Operands are split into `STAGES` equal chunks, with one registered pipeline stage per chunk, and the carry ripples between stages. A valid/ready handshake on both sides allows back-to-back streaming with backpressure. It serves as the datapath adder wherever a wide add must close timing at full clock rate.

## Interface
- `WIDTH`, 16: operand/sum width in bits; must be a multiple of `STAGES`.
- `STAGES`, 4: pipeline depth and chunk count (1..WIDTH); chunk width `CW = WIDTH/STAGES`.

- `clk` input 1: clock, rising-edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: operand beat present.
- `in_ready` output 1: block accepts a beat this cycle.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `cin` input 1: carry in.
- `sub` input 1: subtract mode; present only with `ADDER_SUB_EN`.
- `out_valid` output 1: result beat present.
- `out_ready` input 1: downstream accepts the result.
- `sum` output WIDTH: result.
- `cout` output 1: carry out of MSB.
- `ovf` output 1: two's-complement signed overflow.

## Operation
- Global pipeline enable: `en = !out_valid || out_ready`; `in_ready = en`. The whole pipeline advances only when `en`=1.
- Transfer in: `in_valid && in_ready` at a rising edge. Transfer out: `out_valid && out_ready` at a rising edge.
- Stage k (0..STAGES-1):
  - Adds chunk k of A and B (bits `k*CW +: CW`) plus the carry from stage k-1 (stage 0 uses `cin`).
  - Registers the CW-bit partial sum, the carry, and a valid bit.
  - Carries the not-yet-added higher chunks of A/B and the completed lower sum chunks forward.
- Stage 0 valid loads `in_valid` when `en`=1. A bubble (in_valid=0) propagates as valid=0 and does not hold up later beats.
- `cout`: carry out of chunk STAGES-1.
- `ovf`: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. This is computed in the last stage and registered with the result.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Results emerge strictly in acceptance order; no beat is dropped or duplicated.
- When `en`=0, all stage registers hold. `sum`/`cout`/`ovf` stay stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values: all stage valids=0, all data registers=0.
  - Outputs: `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0, `in_ready`=1.
- Latency: a beat accepted at edge N appears with `out_valid`=1 after edge N+STAGES-1, i.e. STAGES cycles, with no stall.
- Throughput: one beat per cycle while `out_ready`=1.
- Each stall cycle (`out_valid`=1, `out_ready`=0) adds exactly one cycle of latency to every in-flight beat.
- `in_valid` and `out_ready` may change in the same cycle. Simultaneous output and input transfer is legal and required at full rate.
- `STAGES`=1 reduces to a single registered WIDTH-bit adder with latency 1.
- Reset asserted mid-operation clears every in-flight beat immediately, without waiting for a clock edge. The first beat accepted after deassertion is unaffected by pre-reset data.

## Configuration
- `ADDER_SUB_EN` defined:
  - Port `sub` exists and is captured with the operands.
  - When `sub`=1, result = A + ~B + 1: `cin` is ignored and a carry-in of 1 is used.
  - `cout` = 1 means no borrow.
  - `ovf` follows the same carry-XOR rule.
- `ADDER_SUB_EN` undefined:
  - Port `sub` is absent.
  - The block is add-only with `cin` honoured.

## Test plan
- Reset: assert `rst` asynchronously mid-stream with 3 beats in flight. Required response: `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0, `in_ready`=1 with no clock edge needed; no stale beat emerges after release.
- Full carry ripple (WIDTH=16, STAGES=4): A=0xFFFF, B=0x0001, cin=0. Required response: 4 cycles later `sum`=0x0000, `cout`=1, `ovf`=0. Also A=0x7FFF, B=0x0001. Required response: `sum`=0x8000, `cout`=0, `ovf`=1.
- Streaming: 8 vectors on consecutive cycles, including all 8 combinations of chunk-0 A/B/cin LSB patterns, with `out_ready`=1. Required response: 8 consecutive `out_valid` cycles starting 4 cycles after the first accept, each matching the reference model, in order.
- Backpressure: hold `out_ready`=0 for 3 cycles while `out_valid`=1. Required response: `in_ready`=0, `sum`/`cout`/`ovf` stable; on release, all beats delivered exactly once, in order.
- Bubbles: `in_valid` pattern 1,0,1,1,0,1. Required response: `out_valid` shows the identical pattern delayed by STAGES cycles, with correct sums.
- `ADDER_SUB_EN`: `sub`=1, A=0x0005, B=0x0007. Required response: `sum`=0xFFFE, `cout`=0, `ovf`=0. Also A=0x8000, B=0x0001. Required response: `sum`=0x7FFF, `cout`=1, `ovf`=1.
